valinor_sublist: RTL and testbench
==================================

Name: valinor_sublist

Overview:
- Parametrised hardware sublist for the Valinor scheduler. Holds up to DEPTH elements, each an {id, rank, send_time} triple, sorted by rank.
- Accepts one insert per cycle and serves one pop per cycle. A pop returns the lowest-rank element that is eligible, meaning its send_time has been reached.
- Exports a pointer summary for the sublist directory: smallest rank, smallest send_time, num, full.
- Generalises the fixed-width sublist element with configurable depth and widths, and adds wrap-around-safe time eligibility.

Parameters:
- DEPTH, 8, maximum elements held; power of two, at least 2.
- ID_W, 6, element id width.
- RANK_W, 16, rank width.
- TIME_W, 16, send_time and now width; compared modulo 2^TIME_W.
- NUM_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ins_valid  in  1  insert request.
- ins_ready  out  1  insert may be accepted; equals !full.
- ins_id  in  ID_W  inserted element id.
- ins_rank  in  RANK_W  inserted rank.
- ins_send_time  in  TIME_W  inserted send time.
- pop_req  in  1  pop request, single-cycle pulse per request.
- now  in  TIME_W  current time, sampled with pop_req.
- pop_valid  out  1  pop response strobe, one cycle after pop_req.
- pop_found  out  1  response carries an element.
- pop_id  out  ID_W  popped id.
- pop_rank  out  RANK_W  popped rank.
- pop_send_time  out  TIME_W  popped send time.
- num  out  NUM_W  current occupancy.
- full  out  1  num == DEPTH.
- empty  out  1  num == 0.
- smallest_rank  out  RANK_W  rank of slot 0; all-ones when empty.
- smallest_send_time  out  TIME_W  earliest send_time held; all-ones when empty.

Behaviour:
- Storage:
  - Register array slot[0..DEPTH-1], each with a valid bit. Valid slots are contiguous from 0.
  - Slots are sorted by rank ascending; ties are held in insertion order (FIFO).
- Reset (async assert, sync deassert handled upstream):
  - All valid bits 0; num 0; empty 1; full 0; ins_ready 1.
  - pop_valid, pop_found, pop_id, pop_rank and pop_send_time are 0.
  - smallest_rank and smallest_send_time are all-ones.
- Eligibility:
  - Element e is eligible iff the signed (TIME_W-bit) value of (now - e.send_time) is >= 0.
  - Correct while send_times lie within 2^(TIME_W-1) of now.
- Pop, in the cycle pop_req=1:
  - Priority-select the lowest valid index i whose element is eligible.
  - If found: register slot[i] onto the pop_* outputs, set pop_found=1, and shift slots i+1..num-1 down by one.
  - If none found, or the list is empty: pop_found=0, pop_id/rank/send_time=0, array unchanged.
  - pop_valid=1 in the following cycle in either case; otherwise pop_valid=0 and the pop_* data outputs hold their last value.
- Insert, when ins_valid && ins_ready:
  - Position p = number of valid slots with rank <= ins_rank (stable).
  - Slots p.. shift up by one; the new element is written at p.
  - Visible in the array, num and the summary outputs the next cycle.
  - ins_valid while full is ignored: no state change, no error flag.
- Simultaneous insert and pop in the same cycle:
  - Both take effect at the same edge. The pop selects from the pre-edge array.
  - p is computed over the array after removal.
  - num_next = num + accepted - pop_found_next.
  - ins_ready depends only on full; a full list does not accept an insert even when a pop occurs that cycle.
- Summary outputs:
  - Combinational from the registered array, so they are consistent with num in the same cycle.
  - smallest_send_time is a reduction using the wrap-aware compare: a earlier than b iff signed(a - b) < 0.
- Reset during operation: a pop response owed for the next cycle is discarded (pop_valid 0) and all contents are lost.
- No latency beyond one cycle on any path. Throughput is one insert plus one pop per cycle.

Test Plan:
- Reset with DEPTH=8 -> empty=1, num=0, full=0, ins_ready=1, smallest_rank=16'hFFFF, smallest_send_time=16'hFFFF, pop_valid=0.
- Insert (id1,r30), (id2,r10), (id3,r20), all send_time 0; then pop with now=5 three times -> responses id2/r10, id3/r20, id1/r30, each pop_found=1 one cycle after its pop_req; smallest_rank reads 10, 20, 30, then FFFF; empty=1 at the end.
- Insert (id4,r5,st100) and (id5,r9,st10); pop now=50 -> id5 found; pop now=50 again -> pop_found=0, num stays 1; pop now=100 -> id4.
- Wrap-around: insert st=16'hFFF0, pop now=16'h0005 -> found. Separately, st=16'h0010 with now=16'hFFF0 -> pop_found=0.
- Fill 8 entries -> full=1, ins_ready=0; a further ins_valid changes nothing. At num=7, insert plus successful pop in the same cycle -> num stays 7 and the new element sits in sorted position.
- Ties: insert idA r7 then idB r7 -> pops return A then B. Pulling rst_n low in the cycle after pop_req -> pop_valid never asserts, num=0.

Source files
------------

// File: rtl/valinor_sublist.sv
// Rank-sorted sublist for the Valinor scheduler.
// Holds up to DEPTH {id, rank, send_time} elements, packed from slot 0 upward in ascending
// rank order; equal ranks stay in arrival order. Each cycle it accepts one insert and serves
// one pop. A pop returns the lowest-rank element whose send_time has been reached.
// The directory summary (smallest rank, earliest send_time, num, full) is derived from the
// registered array.
module valinor_sublist #(
    parameter int DEPTH  = 8,
    parameter int ID_W   = 6,
    parameter int RANK_W = 16,
    parameter int TIME_W = 16,
    parameter int NUM_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [ID_W-1:0]   ins_id,
    input  logic [RANK_W-1:0] ins_rank,
    input  logic [TIME_W-1:0] ins_send_time,
    input  logic              pop_req,
    input  logic [TIME_W-1:0] now,
    output logic              pop_valid,
    output logic              pop_found,
    output logic [ID_W-1:0]   pop_id,
    output logic [RANK_W-1:0] pop_rank,
    output logic [TIME_W-1:0] pop_send_time,
    output logic [NUM_W-1:0]  num,
    output logic              full,
    output logic              empty,
    output logic [RANK_W-1:0] smallest_rank,
    output logic [TIME_W-1:0] smallest_send_time
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [RANK_W-1:0] rank;
        logic [TIME_W-1:0] st;
    } elem_t;

    // Returns 1 when a is earlier than b on the wrapping time line.
    // A difference with its sign bit set means a lies in the half-circle behind b.
    function automatic logic is_before(input logic [TIME_W-1:0] a, input logic [TIME_W-1:0] b);
        logic [TIME_W-1:0] diff;
        diff = a - b;
        return diff[TIME_W-1];
    endfunction

    elem_t             slot_q [DEPTH];
    elem_t             slot_d [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [NUM_W-1:0]  num_q, num_d;

    elem_t             rm_slot [DEPTH];
    logic [DEPTH-1:0]  rm_vld;
    logic [DEPTH-1:0]  elig;
    logic              found;
    logic [IDX_W-1:0]  sel;
    logic              accept;
    logic [NUM_W-1:0]  ins_pos;
    elem_t             new_elem;
    logic [TIME_W-1:0] min_st;
    logic              have_st;

    logic              pop_valid_q, pop_found_q;
    elem_t             pop_q;

    assign num       = num_q;
    assign full      = (num_q == NUM_W'(DEPTH));
    assign empty     = (num_q == '0);
    assign ins_ready = !full;

    assign pop_valid     = pop_valid_q;
    assign pop_found     = pop_found_q;
    assign pop_id        = pop_q.id;
    assign pop_rank      = pop_q.rank;
    assign pop_send_time = pop_q.st;

    // Pick the lowest-index eligible element. Slot order is rank order, so this is the best candidate.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            elig[i] = pop_req && vld_q[i] && !is_before(now, slot_q[i].st);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (elig[i]) begin
                found = 1'b1;
                sel   = IDX_W'(i);
            end
        end
    end

    // Compute the array after the popped element is removed. Slots above it close the gap.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rm_slot[i] = slot_q[i];
            rm_vld[i]  = vld_q[i];
            if (found && i >= int'(sel)) begin
                if (i < DEPTH - 1) begin
                    rm_slot[i] = slot_q[(i + 1) % DEPTH];
                    rm_vld[i]  = vld_q[(i + 1) % DEPTH];
                end else begin
                    rm_slot[i] = '0;
                    rm_vld[i]  = 1'b0;
                end
            end
        end
    end

    // Place the new element after every remaining element whose rank is less than or equal to
    // its rank. Placing it after equal ranks keeps arrival order among ties.
    always_comb begin
        accept   = ins_valid && !full;
        new_elem = '{id: ins_id, rank: ins_rank, st: ins_send_time};
        ins_pos  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rm_vld[i] && (rm_slot[i].rank <= ins_rank)) begin
                ins_pos = ins_pos + NUM_W'(1);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = rm_slot[i];
            vld_d[i]  = rm_vld[i];
            if (accept) begin
                if (i == int'(ins_pos)) begin
                    slot_d[i] = new_elem;
                    vld_d[i]  = 1'b1;
                end else if (i > int'(ins_pos)) begin
                    slot_d[i] = rm_slot[(i + DEPTH - 1) % DEPTH];
                    vld_d[i]  = rm_vld[(i + DEPTH - 1) % DEPTH];
                end
            end
        end
        num_d = num_q + NUM_W'(accept) - NUM_W'(found);
    end

    // Find the earliest send_time held, using the wrap-aware comparison.
    always_comb begin
        min_st  = '1;
        have_st = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (!have_st || is_before(slot_q[i].st, min_st))) begin
                min_st  = slot_q[i].st;
                have_st = 1'b1;
            end
        end
    end

    assign smallest_send_time = min_st;
    assign smallest_rank      = vld_q[0] ? slot_q[0].rank : '1;

    // Register the sorted array and the occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the slot payloads are also reset. The array is a small flop bank, not a RAM,
            // and the reset keeps the state deterministic for debug.
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            vld_q <= '0;
            num_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            vld_q <= vld_d;
            num_q <= num_d;
        end
    end

    // Register the pop response. The data outputs hold their last value between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_valid_q <= 1'b0;
            pop_found_q <= 1'b0;
            pop_q       <= '0;
        end else begin
            pop_valid_q <= pop_req;
            if (pop_req) begin
                pop_found_q <= found;
                pop_q       <= found ? slot_q[sel] : '0;
            end
        end
    end

endmodule

// File: tb/tb_valinor_sublist.sv
// Directed bench for valinor_sublist. The stimulus pushes the expected pop responses into a
// scoreboard queue. A monitor pops an entry for each pop_valid and compares the response with it.
module tb_valinor_sublist;

    logic        clk;
    logic        rst_n;
    logic        ins_valid;
    logic        ins_ready;
    logic [5:0]  ins_id;
    logic [15:0] ins_rank;
    logic [15:0] ins_send_time;
    logic        pop_req;
    logic [15:0] now;
    logic        pop_valid;
    logic        pop_found;
    logic [5:0]  pop_id;
    logic [15:0] pop_rank;
    logic [15:0] pop_send_time;
    logic [3:0]  num;
    logic        full;
    logic        empty;
    logic [15:0] smallest_rank;
    logic [15:0] smallest_send_time;

    valinor_sublist #(.DEPTH(8), .ID_W(6), .RANK_W(16), .TIME_W(16)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ins_valid          (ins_valid),
        .ins_ready          (ins_ready),
        .ins_id             (ins_id),
        .ins_rank           (ins_rank),
        .ins_send_time      (ins_send_time),
        .pop_req            (pop_req),
        .now                (now),
        .pop_valid          (pop_valid),
        .pop_found          (pop_found),
        .pop_id             (pop_id),
        .pop_rank           (pop_rank),
        .pop_send_time      (pop_send_time),
        .num                (num),
        .full               (full),
        .empty              (empty),
        .smallest_rank      (smallest_rank),
        .smallest_send_time (smallest_send_time)
    );

    typedef struct {
        logic        found;
        logic [5:0]  id;
        logic [15:0] rank;
        logic [15:0] st;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: each response is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (pop_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pop: got id %0h with no response owed (t=%0t)", pop_id, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pop_found",     32'(pop_found),     32'(e.found));
                check("pop_id",        32'(pop_id),        32'(e.id));
                check("pop_rank",      32'(pop_rank),      32'(e.rank));
                check("pop_send_time", 32'(pop_send_time), 32'(e.st));
                check("pop_latency",   32'(cyc),           32'(e.cyc + 1));
            end
        end
    end

    // One cycle of stimulus, driven at the falling edge. An optional pop pushes its expected response.
    task automatic step(input bit do_ins, input logic [5:0] id, input logic [15:0] rk, input logic [15:0] st,
                        input bit do_pop, input logic [15:0] t, input bit ef,
                        input logic [5:0] eid, input logic [15:0] erk, input logic [15:0] est);
        exp_t e;
        ins_valid     = do_ins;
        ins_id        = id;
        ins_rank      = rk;
        ins_send_time = st;
        pop_req       = do_pop;
        now           = t;
        if (do_pop) begin
            e.found = ef;
            e.id    = ef ? eid : 6'd0;
            e.rank  = ef ? erk : 16'd0;
            e.st    = ef ? est : 16'd0;
            e.cyc   = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        ins_valid = 1'b0;
        pop_req   = 1'b0;
    endtask

    task automatic ins(input logic [5:0] id, input logic [15:0] rk, input logic [15:0] st);
        step(1'b1, id, rk, st, 1'b0, 16'd0, 1'b0, 6'd0, 16'd0, 16'd0);
    endtask

    task automatic pop(input logic [15:0] t, input bit ef, input logic [5:0] eid,
                       input logic [15:0] erk, input logic [15:0] est);
        step(1'b0, 6'd0, 16'd0, 16'd0, 1'b1, t, ef, eid, erk, est);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ins_valid = 1'b0; ins_id = '0; ins_rank = '0; ins_send_time = '0;
        pop_req = 1'b0; now = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Values straight out of reset
        check("rst_empty",     32'(empty),              32'd1);
        check("rst_num",       32'(num),                32'd0);
        check("rst_full",      32'(full),               32'd0);
        check("rst_ins_ready", 32'(ins_ready),          32'd1);
        check("rst_srank",     32'(smallest_rank),      32'hFFFF);
        check("rst_sst",       32'(smallest_send_time), 32'hFFFF);
        check("rst_pop_valid", 32'(pop_valid),          32'd0);
        check("rst_pop_id",    32'(pop_id),             32'd0);

        // Inserts arrive out of order, and the pops come out in rank order
        ins(6'd1, 16'd30, 16'd0);
        ins(6'd2, 16'd10, 16'd0);
        ins(6'd3, 16'd20, 16'd0);
        check("sort_num",   32'(num),           32'd3);
        check("sort_srank", 32'(smallest_rank), 32'd10);
        pop(16'd5, 1'b1, 6'd2, 16'd10, 16'd0);
        check("sort_srank_after1", 32'(smallest_rank), 32'd20);
        pop(16'd5, 1'b1, 6'd3, 16'd20, 16'd0);
        check("sort_srank_after2", 32'(smallest_rank), 32'd30);
        pop(16'd5, 1'b1, 6'd1, 16'd30, 16'd0);
        check("sort_srank_after3", 32'(smallest_rank), 32'hFFFF);
        check("sort_empty",        32'(empty),         32'd1);

        // Eligibility: the lowest rank is skipped while its send_time is still in the future
        ins(6'd4, 16'd5, 16'd100);
        ins(6'd5, 16'd9, 16'd10);
        check("elig_sst", 32'(smallest_send_time), 32'd10);
        pop(16'd50,  1'b1, 6'd5, 16'd9, 16'd10);
        pop(16'd50,  1'b0, 6'd0, 16'd0, 16'd0);
        check("elig_num_kept", 32'(num), 32'd1);
        pop(16'd100, 1'b1, 6'd4, 16'd5, 16'd100);
        check("elig_empty", 32'(empty), 32'd1);

        // Wrap-around of the time base
        ins(6'd6, 16'd1, 16'hFFF0);
        ins(6'd7, 16'd2, 16'h0010);
        check("wrap_sst", 32'(smallest_send_time), 32'hFFF0);
        pop(16'h0005, 1'b1, 6'd6, 16'd1, 16'hFFF0);
        pop(16'hFFF0, 1'b0, 6'd0, 16'd0, 16'd0);
        check("wrap_num", 32'(num), 32'd1);
        pop(16'h0010, 1'b1, 6'd7, 16'd2, 16'h0010);

        // Fill the list. An insert while full is ignored.
        for (int k = 0; k < 8; k++) begin
            ins(6'(10 + k), 16'(80 - 10 * k), 16'd0);
        end
        check("fill_full",      32'(full),          32'd1);
        check("fill_ins_ready", 32'(ins_ready),     32'd0);
        check("fill_num",       32'(num),           32'd8);
        ins(6'd20, 16'd1, 16'd0);
        check("full_ignored_num",   32'(num),           32'd8);
        check("full_ignored_srank", 32'(smallest_rank), 32'd10);
        pop(16'd0, 1'b1, 6'd17, 16'd10, 16'd0);
        check("seven_num", 32'(num), 32'd7);

        // Insert and pop in the same cycle at num=7
        step(1'b1, 6'd21, 16'd45, 16'd0, 1'b1, 16'd0, 1'b1, 6'd16, 16'd20, 16'd0);
        check("both_num",   32'(num),           32'd7);
        check("both_srank", 32'(smallest_rank), 32'd30);
        pop(16'd0, 1'b1, 6'd15, 16'd30, 16'd0);
        pop(16'd0, 1'b1, 6'd14, 16'd40, 16'd0);
        pop(16'd0, 1'b1, 6'd21, 16'd45, 16'd0);
        pop(16'd0, 1'b1, 6'd13, 16'd50, 16'd0);
        pop(16'd0, 1'b1, 6'd12, 16'd60, 16'd0);
        pop(16'd0, 1'b1, 6'd11, 16'd70, 16'd0);
        pop(16'd0, 1'b1, 6'd10, 16'd80, 16'd0);
        check("drain_empty", 32'(empty), 32'd1);

        // Equal ranks come out in arrival order
        ins(6'd30, 16'd7, 16'd0);
        ins(6'd31, 16'd7, 16'd0);
        pop(16'd0, 1'b1, 6'd30, 16'd7, 16'd0);
        pop(16'd0, 1'b1, 6'd31, 16'd7, 16'd0);

        // A reset that arrives before the pop is sampled drops the response and the contents
        ins(6'd32, 16'd3, 16'd0);
        check("pre_reset_num", 32'(num), 32'd1);
        pop_req = 1'b1;
        now     = 16'd0;
        #4 rst_n = 1'b0;
        @(negedge clk);
        pop_req = 1'b0;
        check("rst_mid_pop_valid", 32'(pop_valid), 32'd0);
        check("rst_mid_num",       32'(num),       32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_after_pop_valid", 32'(pop_valid), 32'd0);
        check("rst_after_empty",     32'(empty),     32'd1);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
